label_placer_prog: RTL and testbench

Second-generation label placer for the camera-to-DVI overlay path. It sits between the video timing source and the glyph ROM/character renderer. It tracks the raster position and reports whether the current pixel lies inside an N-character text label, plus the character index, glyph row and glyph column. Unlike the fixed-position placer, label position and scale are programmable at runtime through a valid/ready interface. New settings are applied only at frame boundaries, and all outputs are registered with timing signals re-aligned.

---
 rtl/label_pkg.sv | 24 ++
 rtl/label_placer_prog_if.sv | 21 ++
 rtl/label_cfg_shadow.sv | 82 ++++++++
 rtl/label_placer_prog.sv | 168 ++++++++++++++++
 tb/tb_label_placer_prog.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/label_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : label_pkg
//  Description : Shared defaults and width derivations for the label placer
//                (raster counter width, glyph size, place/scale widths).
//  Revision    : 1.0  initial release
// ============================================================================
package label_pkg;

  localparam int LABEL_CNT_W     = 12;
  localparam int LABEL_CHAR_LOG2 = 3;

  // Width of the character index for a label of label_len characters.
  function automatic int place_w(input int label_len);
    return (label_len > 1) ? $clog2(label_len) : 1;
  endfunction

  // Width of the scale exponent field able to hold 0..max_scale.
  function automatic int scale_w(input int max_scale);
    return (max_scale > 0) ? $clog2(max_scale + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/label_placer_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : label_placer_prog_if
//  Description : Runtime configuration channel (valid/ready) carrying the
//                label position and scale exponent.
//  Revision    : 1.0  initial release
// ============================================================================
interface label_placer_prog_if #(
  parameter int CNT_W   = label_pkg::LABEL_CNT_W,
  parameter int SCALE_W = label_pkg::scale_w(3)
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_x;
  logic [CNT_W-1:0]   cfg_y;
  logic [SCALE_W-1:0] cfg_scale;

  modport master (output cfg_valid, cfg_x, cfg_y, cfg_scale, input cfg_ready);
  modport slave  (input cfg_valid, cfg_x, cfg_y, cfg_scale, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/label_cfg_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : label_cfg_shadow
//  Description : Configuration handshake, scale saturation, shadow register
//                with pending flag, and frame-boundary load of the active
//                configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module label_cfg_shadow
  import label_pkg::*;
#(
  parameter int CNT_W     = LABEL_CNT_W,
  parameter int MAX_SCALE = 3,
  parameter int SCALE_W   = scale_w(MAX_SCALE),
  parameter int X_POS     = 256,
  parameter int Y_POS     = 256,
  parameter int SCALE     = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vs_rise,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_x,
  input  logic [CNT_W-1:0]   cfg_y,
  input  logic [SCALE_W-1:0] cfg_scale,
  output logic [CNT_W-1:0]   ax,
  output logic [CNT_W-1:0]   ay,
  output logic [SCALE_W-1:0] asc
);

  logic               r_pending;
  logic [CNT_W-1:0]   r_sx;
  logic [CNT_W-1:0]   r_sy;
  logic [SCALE_W-1:0] r_ssc;
  logic [CNT_W-1:0]   r_ax;
  logic [CNT_W-1:0]   r_ay;
  logic [SCALE_W-1:0] r_asc;
  logic [SCALE_W-1:0] w_scale_sat;
  logic               w_xfer;

  // Saturation only exists when the field can encode values above MAX_SCALE.
  if (MAX_SCALE + 1 < (1 << SCALE_W)) begin : g_sat
    assign w_scale_sat = (cfg_scale > SCALE_W'(MAX_SCALE)) ? SCALE_W'(MAX_SCALE) : cfg_scale;
  end else begin : g_no_sat
    assign w_scale_sat = cfg_scale;
  end

  assign cfg_ready = !r_pending;
  assign w_xfer    = cfg_valid && !r_pending;

  // Shadow capture on a transfer; shadow-to-active copy on the frame boundary.
  // While pending the channel is stalled, so load and capture never collide;
  // a capture coinciding with a vs edge is only applied at the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= 1'b0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_ssc     <= '0;
      r_ax      <= CNT_W'(X_POS);
      r_ay      <= CNT_W'(Y_POS);
      r_asc     <= SCALE_W'(SCALE);
    end else if (vs_rise && r_pending) begin
      r_ax      <= r_sx;
      r_ay      <= r_sy;
      r_asc     <= r_ssc;
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_sx      <= cfg_x;
      r_sy      <= cfg_y;
      r_ssc     <= w_scale_sat;
      r_pending <= 1'b1;
    end
  end

  assign ax  = r_ax;
  assign ay  = r_ay;
  assign asc = r_asc;

endmodule
`default_nettype wire

// File: rtl/label_placer_prog.sv
`default_nettype none
// ============================================================================
//  Module      : label_placer_prog
//  Description : Programmable text-label placer. Tracks the raster position
//                and reports label membership, character index, glyph row
//                and glyph column, registered with re-aligned sync signals.
//                Optional macro LABEL_BLINK_EN adds a frame-counter blink.
//  Revision    : 1.0  initial release
// ============================================================================
module label_placer_prog
  import label_pkg::*;
#(
  parameter int CNT_W      = LABEL_CNT_W,
  parameter int LABEL_LEN  = 8,
  parameter int CHAR_LOG2  = LABEL_CHAR_LOG2,
  parameter int MAX_SCALE  = 3,
  parameter int X_POS      = 256,
  parameter int Y_POS      = 256,
  parameter int SCALE      = 0,
  parameter int BLINK_LOG2 = 5,
  localparam int PLACE_W   = place_w(LABEL_LEN),
  localparam int SCALE_W   = scale_w(MAX_SCALE)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 de,
  label_placer_prog_if.slave   cfg,
  output logic                 in_label,
  output logic [PLACE_W-1:0]   place,
  output logic [CHAR_LOG2-1:0] row,
  output logic [CHAR_LOG2-1:0] pixel,
  output logic                 hs_o,
  output logic                 vs_o,
  output logic                 de_o
);

  localparam int c_LABEL_PIX = LABEL_LEN << CHAR_LOG2;
  localparam int c_CHAR_PIX  = 1 << CHAR_LOG2;
  localparam int c_XR_W      = CHAR_LOG2 + PLACE_W;

  if (LABEL_LEN < 2 || BLINK_LOG2 < 1) begin : g_param_check
    $error("label_placer_prog: LABEL_LEN must be >= 2 and BLINK_LOG2 >= 1");
  end

  logic [CNT_W-1:0]   r_x;
  logic [CNT_W-1:0]   r_y;
  logic               r_hs_d;
  logic               r_vs_d;
  logic               w_hs_rise;
  logic               w_vs_rise;
  logic [CNT_W-1:0]   w_ax;
  logic [CNT_W-1:0]   w_ay;
  logic [SCALE_W-1:0] w_asc;
  logic [CNT_W-1:0]   w_xs;
  logic [CNT_W-1:0]   w_ys;
  logic [CNT_W-1:0]   w_xs0;
  logic [CNT_W-1:0]   w_ys0;
  logic [CNT_W:0]     w_x_end;
  logic [CNT_W:0]     w_y_end;
  logic               w_in_x;
  logic               w_in_y;
  logic [c_XR_W-1:0]  w_xr;
  logic [CHAR_LOG2-1:0] w_yr;
  logic               w_blank;

  assign w_hs_rise = hs && !r_hs_d;
  assign w_vs_rise = vs && !r_vs_d;

  // Raster position: vs clears, hs rising edge starts a new line, de advances.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs_d <= hs;
      r_vs_d <= vs;
      if (vs) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_hs_rise) begin
        r_y <= r_y + CNT_W'(1);
        r_x <= '0;
      end else if (de) begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

  label_cfg_shadow #(
    .CNT_W     (CNT_W),
    .MAX_SCALE (MAX_SCALE),
    .SCALE_W   (SCALE_W),
    .X_POS     (X_POS),
    .Y_POS     (Y_POS),
    .SCALE     (SCALE)
  ) u_cfg_shadow (
    .clk       (clk),
    .rstn      (rstn),
    .vs_rise   (w_vs_rise),
    .cfg_valid (cfg.cfg_valid),
    .cfg_ready (cfg.cfg_ready),
    .cfg_x     (cfg.cfg_x),
    .cfg_y     (cfg.cfg_y),
    .cfg_scale (cfg.cfg_scale),
    .ax        (w_ax),
    .ay        (w_ay),
    .asc       (w_asc)
  );

  // Everything is compared in the scaled domain, so the label origin loses
  // its bits below 2^asc. End bounds carry one extra bit so a label running
  // past the counter limit is clipped rather than wrapping to x/y = 0.
  assign w_xs    = r_x >> w_asc;
  assign w_ys    = r_y >> w_asc;
  assign w_xs0   = w_ax >> w_asc;
  assign w_ys0   = w_ay >> w_asc;
  assign w_x_end = {1'b0, w_xs0} + (CNT_W+1)'(c_LABEL_PIX);
  assign w_y_end = {1'b0, w_ys0} + (CNT_W+1)'(c_CHAR_PIX);
  assign w_in_x  = (w_xs >= w_xs0) && ({1'b0, w_xs} < w_x_end);
  assign w_in_y  = (w_ys >= w_ys0) && ({1'b0, w_ys} < w_y_end);
  assign w_xr    = c_XR_W'(w_xs - w_xs0);
  assign w_yr    = CHAR_LOG2'(w_ys - w_ys0);

`ifdef LABEL_BLINK_EN
  logic [BLINK_LOG2-1:0] r_frame_cnt;

  // Frame counter for blinking; label hidden while its MSB is set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
    end else if (w_vs_rise) begin
      r_frame_cnt <= r_frame_cnt + BLINK_LOG2'(1);
    end
  end

  assign w_blank = r_frame_cnt[BLINK_LOG2-1];
`else
  assign w_blank = 1'b0;
`endif

  // Output stage: one clock after the counter state it describes, with the
  // sync inputs delayed by the same single register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_label <= 1'b0;
      place    <= '0;
      row      <= '0;
      pixel    <= '0;
      hs_o     <= 1'b0;
      vs_o     <= 1'b0;
      de_o     <= 1'b0;
    end else begin
      in_label <= w_in_x && w_in_y && !w_blank;
      place    <= w_xr[c_XR_W-1:CHAR_LOG2];
      pixel    <= w_xr[CHAR_LOG2-1:0];
      row      <= w_yr;
      hs_o     <= hs;
      vs_o     <= vs;
      de_o     <= de;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_label_placer_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_label_placer_prog
//  Description : Directed, table-driven bench for label_placer_prog with the
//                default parameter set (12-bit counters, 8 chars of 8x8,
//                MAX_SCALE 3, label at 256,256, scale 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_label_placer_prog;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       hs   = 1'b0;
  logic       vs   = 1'b0;
  logic       de   = 1'b0;
  logic       in_label;
  logic [2:0] place;
  logic [2:0] row;
  logic [2:0] pixel;
  logic       hs_o;
  logic       vs_o;
  logic       de_o;

  label_placer_prog_if #(.CNT_W(12), .SCALE_W(2)) cfg_if ();

  label_placer_prog dut (
    .clk      (clk),
    .rstn     (rstn),
    .hs       (hs),
    .vs       (vs),
    .de       (de),
    .cfg      (cfg_if),
    .in_label (in_label),
    .place    (place),
    .row      (row),
    .pixel    (pixel),
    .hs_o     (hs_o),
    .vs_o     (vs_o),
    .de_o     (de_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int x;
    bit exp_in;
    bit chk_pos;
    int exp_place;
    int exp_row;
    int exp_pixel;
  } vec_t;

  vec_t vecs [48];
  int   nv        = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  function automatic void add(input int y, input int x, input bit ein,
                              input bit cpos, input int p, input int r, input int px);
    vecs[nv] = '{y, x, ein, cpos, p, r, px};
    nv++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame start, y hs pulses, x de cycles, then one idle cycle so the
  // registered outputs describe counter position (x, y).
  task automatic goto(input int y, input int x);
    hs = 1'b0; de = 1'b0; vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    for (int i = 0; i < y; i++) begin
      hs = 1'b1; tick();
      hs = 1'b0; tick();
    end
    de = 1'b1;
    for (int i = 0; i < x; i++) tick();
    de = 1'b0;
    tick();
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      goto(vecs[i].y, vecs[i].x);
      check($sformatf("in_label v%0d (%0d,%0d)", i, vecs[i].x, vecs[i].y), {31'd0, in_label}, {31'd0, vecs[i].exp_in});
      if (vecs[i].chk_pos) begin
        check($sformatf("place v%0d", i), {29'd0, place}, vecs[i].exp_place);
        check($sformatf("row v%0d", i),   {29'd0, row},   vecs[i].exp_row);
        check($sformatf("pixel v%0d", i), {29'd0, pixel}, vecs[i].exp_pixel);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_label"}, {31'd0, in_label}, 0);
    check({tag, " place"},    {29'd0, place},    0);
    check({tag, " row"},      {29'd0, row},      0);
    check({tag, " pixel"},    {29'd0, pixel},    0);
    check({tag, " syncs"},    {29'd0, hs_o, vs_o, de_o}, 0);
    check({tag, " cfg_ready"}, {31'd0, cfg_if.cfg_ready}, 1);
  endtask

  task automatic offer(input int x, input int y, input logic [1:0] sc);
    cfg_if.cfg_x     = 12'(x);
    cfg_if.cfg_y     = 12'(y);
    cfg_if.cfg_scale = sc;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  int d_lo, d_hi, s2_lo, s2_hi, s3_lo, s3_hi, w_lo, w_hi;
  logic [2:0] pats [4];

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_x     = '0;
    cfg_if.cfg_y     = '0;
    cfg_if.cfg_scale = '0;

    // default placement: x 256..319, y 256..263
    d_lo = nv;
    add(256, 256, 1, 1, 0, 0, 0);
    add(256, 255, 0, 0, 0, 0, 0);
    add(256, 263, 1, 1, 0, 0, 7);
    add(256, 264, 1, 1, 1, 0, 0);
    add(259, 300, 1, 1, 5, 3, 4);
    add(263, 319, 1, 1, 7, 7, 7);
    add(263, 320, 0, 0, 0, 0, 0);
    add(264, 256, 0, 0, 0, 0, 0);
    add(255, 300, 0, 0, 0, 0, 0);
    d_hi = nv;
    // scale 2 at 512,128: x 512..767, y 128..159, 4 px per glyph pixel
    s2_lo = nv;
    add(128, 512, 1, 1, 0, 0, 0);
    add(128, 511, 0, 0, 0, 0, 0);
    add(128, 515, 1, 1, 0, 0, 0);
    add(128, 516, 1, 1, 0, 0, 1);
    add(159, 767, 1, 1, 7, 7, 7);
    add(160, 767, 0, 0, 0, 0, 0);
    add(127, 600, 0, 0, 0, 0, 0);
    add(130, 768, 0, 0, 0, 0, 0);
    add(140, 700, 1, 1, 5, 3, 7);
    add(256, 256, 0, 0, 0, 0, 0);
    s2_hi = nv;
    // saturated scale 3 at 512,128: x 512..1023, y 128..191
    s3_lo = nv;
    add(128, 512, 1, 1, 0, 0, 0);
    add(128, 520, 1, 1, 0, 0, 1);
    add(191, 1023, 1, 1, 7, 7, 7);
    add(192, 1000, 0, 0, 0, 0, 0);
    add(150, 1024, 0, 0, 0, 0, 0);
    add(135, 600, 1, 1, 1, 0, 3);
    add(136, 519, 1, 1, 0, 1, 0);
    s3_hi = nv;
    // label at 4040,0 scale 0: clipped at 4095, no wrap to x=0
    w_lo = nv;
    add(0, 4040, 1, 1, 0, 0, 0);
    add(3, 4095, 1, 1, 6, 3, 7);
    add(7, 4041, 1, 1, 0, 7, 1);
    add(0, 4039, 0, 0, 0, 0, 0);
    add(0, 4096, 0, 0, 0, 0, 0);
    add(8, 4050, 0, 0, 0, 0, 0);
    w_hi = nv;

    // reset state with busy inputs
    hs = 1'b1; de = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    hs = 1'b0; de = 1'b0;
    rstn = 1'b1;
    tick();

    // sync re-alignment: exactly one clock of delay
    pats[0] = 3'b101; pats[1] = 3'b010; pats[2] = 3'b001; pats[3] = 3'b110;
    for (int i = 0; i < 4; i++) begin
      {hs, vs, de} = pats[i];
      tick();
      check($sformatf("syncs pattern %0d", i), {29'd0, hs_o, vs_o, de_o}, {29'd0, pats[i]});
    end
    {hs, vs, de} = 3'b000;
    tick();

    run_table(d_lo, d_hi);

    // mid-frame transfer must not disturb the current frame
    goto(259, 300);
    offer(512, 128, 2'd2);
    check("cfg_ready after transfer", {31'd0, cfg_if.cfg_ready}, 0);
    check("mid-frame in_label", {31'd0, in_label}, 1);
    check("mid-frame place", {29'd0, place}, 5);
    // second offer while pending is stalled and must not be captured
    cfg_if.cfg_x = 12'd4040; cfg_if.cfg_y = 12'd0; cfg_if.cfg_scale = 2'd0;
    cfg_if.cfg_valid = 1'b1;
    de = 1'b1;
    repeat (4) tick();
    de = 1'b0;
    tick();
    check("cfg_ready while pending", {31'd0, cfg_if.cfg_ready}, 0);
    check("mid-frame x=304 in_label", {31'd0, in_label}, 1);
    check("mid-frame x=304 place", {29'd0, place}, 6);
    cfg_if.cfg_valid = 1'b0;
    vs = 1'b1;
    tick();
    vs = 1'b0;
    check("cfg_ready after vs edge", {31'd0, cfg_if.cfg_ready}, 1);
    tick();

    run_table(s2_lo, s2_hi);

    // scale request of 7 arrives truncated to the 2-bit field and lands on 3
    offer(512, 128, 2'(7));
    check("cfg_ready after scale-7 transfer", {31'd0, cfg_if.cfg_ready}, 0);
    run_table(s3_lo, s3_hi);

    offer(4040, 0, 2'd0);
    run_table(w_lo, w_hi);

    // async reset in the middle of the label, with a pending config
    goto(3, 4050);
    check("pre-reset in_label", {31'd0, in_label}, 1);
    check("pre-reset place", {29'd0, place}, 1);
    offer(512, 128, 2'd2);
    #2 rstn = 1'b0;
    #1 check_all_zero("async reset");
    tick();
    rstn = 1'b1;
    goto(256, 256);
    check("post-reset default in_label", {31'd0, in_label}, 1);
    check("post-reset default place", {29'd0, place}, 0);
    goto(128, 512);
    check("post-reset discarded cfg", {31'd0, in_label}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
